// File: rtl/snake_pkg.sv
// Shared constants, cell encodings and FSM state type for the snake board buffer.
// Optional read bypass is selected with SNAKE_BOARD_RD_BYPASS_EN (see snake_board_buffer).
package snake_pkg;

  localparam int BOARD_DEPTH = 1024;
  localparam int CELL_W      = 16;
  localparam int SCORE_MAX   = 999;
  localparam int ADDR_W      = $clog2(BOARD_DEPTH);
  localparam int SCORE_W     = 10;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 16'h0000;
  localparam logic [CELL_W-1:0] CELL_SNAKE = 16'h0001;
  localparam logic [CELL_W-1:0] CELL_FOOD  = 16'h0002;
  localparam logic [CELL_W-1:0] CELL_HEAD  = 16'h0003;

  typedef enum logic {S_IDLE, S_CLEAR} board_state_t;

  // Saturating +1 used by the score counter.
  function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] s,
                                                       input logic [SCORE_W-1:0] max);
    return (s >= max) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/board_ram.sv
// Simple dual-port synchronous RAM: one write port, one enabled read port,
// read-before-write on a same-address collision. Only the read register is reset.
module board_ram #(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch so it maps onto block RAM; the
  // owner of this RAM is responsible for initialising its contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: non-blocking assignments on both ports are what give read-before-write:
  // the read samples mem before the same edge's write lands.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/snake_board_buffer.sv
// Board-state store feeding the VGA top: cell RAM, clear sequencer and score counter.
// Define SNAKE_BOARD_RD_BYPASS_EN for write-first forwarding on read/write collisions.
module snake_board_buffer
  import snake_pkg::*;
#(
  parameter  int DEPTH     = snake_pkg::BOARD_DEPTH,
  parameter  int WORD_W    = snake_pkg::CELL_W,
  parameter  int SCORE_MAX = snake_pkg::SCORE_MAX,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [WORD_W-1:0]  state,
  input  logic               wr_en,
  input  logic [AW-1:0]      waddr,
  input  logic [WORD_W-1:0]  wdata,
  output logic               wr_ready,
  input  logic               clear_req,
  output logic               busy,
  output logic               clear_done,
  input  logic               score_inc,
  output logic [SCORE_W-1:0] score
);

  board_state_t       state_q, state_d;
  logic [AW-1:0]      clr_addr_q, clr_addr_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               clear_done_q, clear_done_d;

  logic               ram_we;
  logic [AW-1:0]      ram_waddr;
  logic [WORD_W-1:0]  ram_wdata;
  logic [WORD_W-1:0]  ram_rdata;

  assign busy       = (state_q == S_CLEAR);
  assign wr_ready   = ~busy;
  assign clear_done = clear_done_q;
  assign score      = score_q;

  // The clear sequencer owns the write port while busy; game writes are dropped.
  assign ram_we    = ~reset & (busy | wr_en);
  assign ram_waddr = busy ? clr_addr_q : waddr;
  assign ram_wdata = busy ? WORD_W'(CELL_EMPTY) : wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clr_addr_q   <= '0;
      score_q      <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      score_q      <= score_d;
      clear_done_q <= clear_done_d;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    score_d      = score_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
          score_d    = '0;
        end else if (score_inc) begin
          score_d = score_sat_inc(score_q, SCORE_W'(SCORE_MAX));
        end
      end
      S_CLEAR: begin
        // A new request restarts the sweep and suppresses the pending done pulse.
        if (clear_req) begin
          clr_addr_d = '0;
          score_d    = '0;
        end else if (clr_addr_q == AW'(DEPTH - 1)) begin
          state_d      = S_IDLE;
          clear_done_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  board_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_board_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

`ifdef SNAKE_BOARD_RD_BYPASS_EN
  logic              fwd_sel_q;
  logic [WORD_W-1:0] fwd_data_q;

  // Selection only updates on a read so state still holds while re is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_sel_q  <= 1'b0;
      fwd_data_q <= '0;
    end else if (re) begin
      fwd_sel_q  <= ram_we & (raddr == ram_waddr);
      fwd_data_q <= ram_wdata;
    end
  end

  assign state = fwd_sel_q ? fwd_data_q : ram_rdata;
`else
  assign state = ram_rdata;
`endif

endmodule

// File: tb/tb_snake_board_buffer.sv
// Self-checking bench for snake_board_buffer: directed vectors, clear-timing
// sequences and randomized traffic against a behavioural board model.
module tb_snake_board_buffer;

`ifdef SNAKE_BOARD_RD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, re, wr_en, clear_req, score_inc;
  logic [9:0]  raddr, waddr;
  logic [15:0] wdata;
  logic [15:0] state;
  logic        wr_ready, busy, clear_done;
  logic [9:0]  score;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the board.
  logic [15:0] m_mem [1024];
  bit          m_busy;
  logic [9:0]  m_clr;
  logic [9:0]  m_score;
  logic [15:0] m_state;
  bit          m_done;

  typedef struct {
    bit          re;
    logic [9:0]  raddr;
    bit          wr_en;
    logic [9:0]  waddr;
    logic [15:0] wdata;
    bit          score_inc;
    logic [15:0] exp_state;
    logic [9:0]  exp_score;
  } vec_t;

  vec_t vecs [12];

  snake_board_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .re         (re),
    .raddr      (raddr),
    .state      (state),
    .wr_en      (wr_en),
    .waddr      (waddr),
    .wdata      (wdata),
    .wr_ready   (wr_ready),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .score_inc  (score_inc),
    .score      (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit r, input logic [9:0] ra, input bit we,
                              input logic [9:0] wa, input logic [15:0] wd, input bit si,
                              input logic [15:0] es, input logic [9:0] esc);
    vec_t v;
    v.re = r; v.raddr = ra; v.wr_en = we; v.waddr = wa; v.wdata = wd;
    v.score_inc = si; v.exp_state = es; v.exp_score = esc;
    return v;
  endfunction

  // One clock: drive inputs, take the edge, advance the model by the board rules.
  task automatic cycle(input bit rst, input bit r, input logic [9:0] ra, input bit we,
                       input logic [9:0] wa, input logic [15:0] wd, input bit cr,
                       input bit si);
    bit          wr_any;
    logic [9:0]  wa_eff;
    logic [15:0] wd_eff;
    reset = rst; re = r; raddr = ra; wr_en = we; waddr = wa; wdata = wd;
    clear_req = cr; score_inc = si;
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b1; m_clr = 10'd0; m_score = 10'd0; m_state = 16'h0; m_done = 1'b0;
    end else begin
      wr_any = m_busy || we;
      wa_eff = m_busy ? m_clr : wa;
      wd_eff = m_busy ? 16'h0 : wd;
      if (r) m_state = (BYPASS && wr_any && wa_eff == ra) ? wd_eff : m_mem[ra];
      if (wr_any) m_mem[wa_eff] = wd_eff;
      m_done = 1'b0;
      if (cr) begin
        m_busy = 1'b1; m_clr = 10'd0; m_score = 10'd0;
      end else if (m_busy) begin
        if (m_clr == 10'd1023) begin
          m_busy = 1'b0; m_done = 1'b1;
        end else begin
          m_clr = m_clr + 10'd1;
        end
      end else if (si && m_score < 10'd999) begin
        m_score = m_score + 10'd1;
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic read(input logic [9:0] a);
    cycle(1'b0, 1'b1, a, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic compare_model();
    check("state", 32'(state), 32'(m_state));
    check("busy", 32'(busy), 32'(m_busy));
    check("wr_ready", 32'(wr_ready), 32'(!m_busy));
    check("clear_done", 32'(clear_done), 32'(m_done));
    check("score", 32'(score), 32'(m_score));
  endtask

  // Counts cycles until clear_done; probes a dropped write to addr 10 late in the sweep.
  task automatic wait_done(input int exp_n, input string name);
    int n;
    n = -1;
    for (int i = 1; i <= 1100; i++) begin
      if (i == 600) cycle(1'b0, 1'b0, 10'd0, 1'b1, 10'd10, 16'hBEEF, 1'b0, 1'b0);
      else          idle();
      compare_model();
      if (clear_done === 1'b1) begin
        n = i;
        break;
      end
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = 16'h0;
    reset = 1'b1; re = 1'b0; raddr = '0; wr_en = 1'b0; waddr = '0; wdata = '0;
    clear_req = 1'b0; score_inc = 1'b0;
    m_busy = 1'b1; m_clr = '0; m_score = '0; m_state = '0; m_done = 1'b0;

    vecs[0]  = mk(1'b0, 10'd0,    1'b1, 10'd37,   16'hA5A5, 1'b0, 16'h0000, 10'd0);
    vecs[1]  = mk(1'b1, 10'd37,   1'b0, 10'd0,    16'h0000, 1'b0, 16'hA5A5, 10'd0);
    vecs[2]  = mk(1'b1, 10'd38,   1'b0, 10'd0,    16'h0000, 1'b0, 16'h0000, 10'd0);
    vecs[3]  = mk(1'b0, 10'd0,    1'b1, 10'd5,    16'h1111, 1'b0, 16'h0000, 10'd0);
    vecs[4]  = mk(1'b1, 10'd5,    1'b1, 10'd5,    16'h2222, 1'b0,
                  BYPASS ? 16'h2222 : 16'h1111, 10'd0);
    vecs[5]  = mk(1'b1, 10'd5,    1'b0, 10'd0,    16'h0000, 1'b0, 16'h2222, 10'd0);
    vecs[6]  = mk(1'b0, 10'd0,    1'b0, 10'd0,    16'h0000, 1'b1, 16'h2222, 10'd1);
    vecs[7]  = mk(1'b1, 10'd37,   1'b0, 10'd0,    16'h0000, 1'b1, 16'hA5A5, 10'd2);
    vecs[8]  = mk(1'b1, 10'd1023, 1'b1, 10'd1023, 16'hFFFF, 1'b0,
                  BYPASS ? 16'hFFFF : 16'h0000, 10'd2);
    vecs[9]  = mk(1'b1, 10'd1023, 1'b0, 10'd0,    16'h0000, 1'b0, 16'hFFFF, 10'd2);
    vecs[10] = mk(1'b0, 10'd0,    1'b1, 10'd0,    16'h1234, 1'b1, 16'hFFFF, 10'd3);
    vecs[11] = mk(1'b1, 10'd0,    1'b0, 10'd0,    16'h0000, 1'b0, 16'h1234, 10'd3);

    // Power-up reset and the first full clear.
    repeat (3) cycle(1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0);
    check("rst_state", 32'(state), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_wr_ready", 32'(wr_ready), 32'h0);
    check("rst_done", 32'(clear_done), 32'h0);
    check("rst_score", 32'(score), 32'h0);
    wait_done(1024, "clr_len_reset");
    idle();
    check("done_single_pulse", 32'(clear_done), 32'h0);
    read(10'd0);
    check("rd_addr0", 32'(state), 32'h0);
    read(10'd1023);
    check("rd_addr1023", 32'(state), 32'h0);
    read(10'd10);
    check("drop_wr_reset_clr", 32'(state), 32'h0);

    // Directed write/read/collision/score vectors.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, vecs[i].re, vecs[i].raddr, vecs[i].wr_en, vecs[i].waddr,
            vecs[i].wdata, 1'b0, vecs[i].score_inc);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_score", i), 32'(score), 32'(vecs[i].exp_score));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
    end

    // Score saturation, then score_inc colliding with clear_req.
    repeat (1005) cycle(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b1);
    check("score_sat", 32'(score), 32'd999);
    compare_model();
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 16'h0, 1'b1, 1'b1);
    check("clr_wins_score", 32'(score), 32'h0);
    check("clr_wins_busy", 32'(busy), 32'h1);

    // Restart at clear cycle 500: the aborted sweep must not pulse done.
    for (int i = 0; i < 499; i++) begin
      idle();
      compare_model();
    end
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 16'h0, 1'b1, 1'b0);
    compare_model();
    wait_done(1024, "clr_len_restart");
    read(10'd10);
    check("drop_wr_busy", 32'(state), 32'h0);
    read(10'd37);
    check("clr_wiped_37", 32'(state), 32'h0);

    // Reset asserted in the middle of a clear.
    cycle(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      idle();
      compare_model();
    end
    cycle(1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0);
    check("midrst_busy", 32'(busy), 32'h1);
    check("midrst_state", 32'(state), 32'h0);
    wait_done(1024, "clr_len_reset_mid");

    // Randomized traffic against the model; narrow addresses provoke collisions.
    for (int i = 0; i < 6000; i++) begin
      automatic bit          r_rst = ($urandom_range(0, 3999) == 0);
      automatic bit          r_cr  = ($urandom_range(0, 2499) == 0);
      automatic bit          r_re  = 1'($urandom_range(0, 1));
      automatic bit          r_we  = 1'($urandom_range(0, 1));
      automatic bit          r_si  = 1'($urandom_range(0, 1));
      automatic logic [9:0]  r_ra  = ($urandom_range(0, 7) == 0) ? 10'($urandom)
                                                                 : 10'($urandom_range(0, 15));
      automatic logic [9:0]  r_wa  = ($urandom_range(0, 7) == 0) ? 10'($urandom)
                                                                 : 10'($urandom_range(0, 15));
      automatic logic [15:0] r_wd  = 16'($urandom);
      cycle(r_rst, r_re, r_ra, r_we, r_wa, r_wd, r_cr, r_si);
      compare_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
